mem_access_unit: RTL and testbench

- Load/store sequencer placed directly upstream of the byte-addressed data memory (65536 x 8, little-endian).
- The memory reads 4 bytes combinationally and always writes 4 bytes at posedge.
- This block turns CPU byte/half/word load and store requests into memory cycles.
- Sub-word stores use read-modify-write; loads are sign- or zero-extended.
- It presents a req/done handshake to the datapath controller.

---
 rtl/mem_pkg.sv | 10 +
 rtl/mem_data_align.sv | 20 ++
 rtl/mem_access_unit.sv | 83 ++++++++
 tb/tb_mem_access_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings and limits for the load/store sequencer
package mem_pkg;
    localparam int MEM_BYTES = 65536;
    localparam int DW = 32;
    localparam logic [DW-1:0] MEM_LAST_LEGAL = DW'(MEM_BYTES - 4);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
endpackage

// File: rtl/mem_data_align.sv
// mem_data_align: load extension and sub-word store merge on the memory word
module mem_data_align
    import mem_pkg::*;
(
    input  logic [1:0]    size,
    input  logic          sign_ext,
    input  logic [DW-1:0] rd_word,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] load_ext,
    output logic [DW-1:0] store_merge
);
    always_comb begin
        load_ext = size == SZ_BYTE ? {{24{sign_ext & rd_word[7]}}, rd_word[7:0]}
                 : size == SZ_HALF ? {{16{sign_ext & rd_word[15]}}, rd_word[15:0]}
                 : rd_word;
        store_merge = size == SZ_BYTE ? {rd_word[31:8], wdata[7:0]}
                    : size == SZ_HALF ? {rd_word[31:16], wdata[15:0]}
                    : wdata;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns byte/half/word load-store requests into memory cycles
module mem_access_unit
    import mem_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          sign_ext,
    input  logic [DW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic [DW-1:0] mem_adr,
    output logic [DW-1:0] mem_d_in,
    output logic          mem_mrd,
    output logic          mem_mwr,
    input  logic [DW-1:0] mem_d_out
);
    state_t state, next;
    logic we_r, sx_r, err_r, illegal;
    logic [1:0] size_r;
    logic [DW-1:0] wdata_r, load_ext, store_merge;

    assign illegal = size > SZ_WORD || addr > MEM_LAST_LEGAL;
    assign busy = state != IDLE;
    assign done = state == RESP;
    assign err = done & err_r;
    assign mem_mrd = state == RD;
    assign mem_mwr = state == WR;

    mem_data_align u_align (
        .size(size_r),
        .sign_ext(sx_r),
        .rd_word(mem_d_out),
        .wdata(wdata_r),
        .load_ext(load_ext),
        .store_merge(store_merge)
    );

    always_comb begin
        next = state;
        case (state)
            IDLE: next = !req ? IDLE : illegal ? RESP : (we && size == SZ_WORD) ? WR : RD;
            RD: next = we_r ? WR : RESP;
            WR: next = RESP;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            we_r <= 1'b0;
            sx_r <= 1'b0;
            err_r <= 1'b0;
            size_r <= SZ_BYTE;
            wdata_r <= '0;
            rdata <= '0;
            mem_adr <= '0;
            mem_d_in <= '0;
        end else begin
            state <= next;
            if (state == IDLE && req) begin
                mem_adr <= addr;
                we_r <= we;
                size_r <= size;
                sx_r <= sign_ext;
                wdata_r <= wdata;
                err_r <= illegal;
                if (!illegal && we && size == SZ_WORD) mem_d_in <= wdata;
            end
            // the read word is consumed at the RD edge: either as a load result or merge base
            if (state == RD) begin
                if (we_r) mem_d_in <= store_merge;
                else rdata <= load_ext;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed stimulus with a transaction-level reference model
module tb_mem_access_unit;
    logic clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, sign_ext = 1'b0;
    logic [1:0] size = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic busy, done, err, mem_mrd, mem_mwr;
    logic [31:0] rdata, mem_adr, mem_d_in, mem_d_out;
    bit [7:0] mem [0:65535];
    bit [7:0] ref_mem [0:65535];
    int n_chk = 0, n_pass = 0;
    int last_nrd, last_nwr, last_nbusy;
    logic [31:0] last_wd;
    logic [15:0] a16;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_adr(mem_adr), .mem_d_in(mem_d_in), .mem_mrd(mem_mrd), .mem_mwr(mem_mwr),
        .mem_d_out(mem_d_out)
    );

    always #5 clk = ~clk;

    assign a16 = mem_adr[15:0];
    assign mem_d_out = {mem[a16 + 16'd3], mem[a16 + 16'd2], mem[a16 + 16'd1], mem[a16]};
    always @(posedge clk)
        if (mem_mwr)
            for (int i = 0; i < 4; i++) mem[a16 + 16'(i)] <= mem_d_in[8*i +: 8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    endtask

    // reference model: one transaction at a time, described by latency and byte effects
    int m_cnt = 0, m_lat = 1;
    logic m_err = 1'b0, m_rd = 1'b0, m_wr = 1'b0;
    logic [31:0] m_adr = '0, m_load = '0, m_wword = '0, m_rdata = '0;

    function automatic logic [31:0] word_at(input logic [15:0] a);
        return {ref_mem[a + 16'd3], ref_mem[a + 16'd2], ref_mem[a + 16'd1], ref_mem[a]};
    endfunction

    function automatic logic [31:0] ld_val(input logic [31:0] raw, input logic [1:0] s, input logic x);
        if (s == 2'b00) return x ? 32'($signed(raw[7:0])) : 32'(raw[7:0]);
        if (s == 2'b01) return x ? 32'($signed(raw[15:0])) : 32'(raw[15:0]);
        return raw;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] raw, input logic [31:0] d, input logic [1:0] s);
        logic [31:0] o;
        int nb;
        nb = s == 2'b00 ? 1 : s == 2'b01 ? 2 : 4;
        for (int i = 0; i < 4; i++) o[8*i +: 8] = i < nb ? d[8*i +: 8] : raw[8*i +: 8];
        return o;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0;
            m_rdata <= '0;
        end else if (m_cnt == 0) begin
            if (req) begin
                m_adr <= addr;
                m_err <= size == 2'b11 || addr > 32'd65532;
                m_rd <= !(size == 2'b11 || addr > 32'd65532) && (!we || size != 2'b10);
                m_wr <= !(size == 2'b11 || addr > 32'd65532) && we;
                m_lat <= (size == 2'b11 || addr > 32'd65532) ? 1 : (we && size != 2'b10) ? 3 : 2;
                m_load <= ld_val(word_at(addr[15:0]), size, sign_ext);
                m_wword <= merge(word_at(addr[15:0]), wdata, size);
                m_cnt <= 1;
            end
        end else begin
            if (m_wr && m_cnt == m_lat - 1)
                for (int i = 0; i < 4; i++) ref_mem[m_adr[15:0] + 16'(i)] <= m_wword[8*i +: 8];
            if (!m_wr && !m_err && m_cnt == m_lat - 1) m_rdata <= m_load;
            m_cnt <= m_cnt == m_lat ? 0 : m_cnt + 1;
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_cnt != 0));
        check("done", 32'(done), 32'(m_cnt != 0 && m_cnt == m_lat));
        check("err", 32'(err), 32'(m_cnt != 0 && m_cnt == m_lat && m_err));
        check("mem_mrd", 32'(mem_mrd), 32'(m_cnt == 1 && m_rd));
        check("mem_mwr", 32'(mem_mwr), 32'(m_cnt != 0 && m_cnt == m_lat - 1 && m_wr));
        check("rdata", rdata, m_rdata);
        if (m_cnt != 0) check("mem_adr", mem_adr, m_adr);
        if (m_cnt != 0 && m_cnt == m_lat - 1 && m_wr) check("mem_d_in", mem_d_in, m_wword);
    end

    task automatic op(input logic w, input logic [1:0] s, input logic x, input logic [31:0] a,
                      input logic [31:0] d, input int lat, input logic e, input bit hold);
        int n;
        req = 1'b1; we = w; size = s; sign_ext = x; addr = a; wdata = d;
        @(posedge clk); #1;
        if (!hold) req = 1'b0;
        n = 1; last_nrd = 0; last_nwr = 0; last_nbusy = 0; last_wd = '0;
        while (!done && n < 8) begin
            last_nrd += int'(mem_mrd);
            last_nbusy += int'(busy);
            if (mem_mwr) begin last_nwr++; last_wd = mem_d_in; end
            @(posedge clk); #1;
            n++;
        end
        last_nbusy += int'(busy);
        check("latency", 32'(n), 32'(lat));
        check("err_at_done", 32'(err), 32'(e));
        @(posedge clk); #1;
    endtask

    initial begin
        mem[1000] <= 8'h80; mem[1001] <= 8'h12; mem[1002] <= 8'h34; mem[1003] <= 8'h56;
        ref_mem[1000] <= 8'h80; ref_mem[1001] <= 8'h12; ref_mem[1002] <= 8'h34; ref_mem[1003] <= 8'h56;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_outs", {26'd0, done, err, mem_mrd, mem_mwr, 2'b0}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_adr", mem_adr, 32'd0);
        check("rst_mem_d_in", mem_d_in, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        op(1'b0, 2'b00, 1'b1, 32'd1000, 32'd0, 2, 1'b0, 1'b0);
        check("lb_sx", rdata, 32'hFFFFFF80);
        op(1'b0, 2'b00, 1'b0, 32'd1000, 32'd0, 2, 1'b0, 1'b0);
        check("lb_zx", rdata, 32'h00000080);
        op(1'b1, 2'b01, 1'b0, 32'd1000, 32'hDEADBEEF, 3, 1'b0, 1'b0);
        check("sh_rd_cycles", 32'(last_nrd), 32'd1);
        check("sh_wr_cycles", 32'(last_nwr), 32'd1);
        check("sh_wdata", last_wd, 32'h5634BEEF);
        check("sh_rdata_kept", rdata, 32'h00000080);
        op(1'b0, 2'b10, 1'b0, 32'd1000, 32'd0, 2, 1'b0, 1'b0);
        check("lw", rdata, 32'h5634BEEF);
        op(1'b0, 2'b01, 1'b1, 32'd1000, 32'd0, 2, 1'b0, 1'b0);
        check("lh_sx", rdata, 32'hFFFFBEEF);
        op(1'b0, 2'b01, 1'b1, 32'd1001, 32'd0, 2, 1'b0, 1'b0);
        check("lh_unaligned", rdata, 32'h000034BE);
        op(1'b0, 2'b00, 1'b1, 32'd1001, 32'd0, 2, 1'b0, 1'b0);
        check("lb_unaligned", rdata, 32'hFFFFFFBE);
        op(1'b1, 2'b10, 1'b0, 32'd200, 32'hCAFEF00D, 2, 1'b0, 1'b0);
        check("sw_no_rd", 32'(last_nrd), 32'd0);
        check("sw_bytes", {mem[203], mem[202], mem[201], mem[200]}, 32'hCAFEF00D);
        check("sw_byte200", 32'(mem[200]), 32'h0D);
        op(1'b0, 2'b11, 1'b0, 32'd1000, 32'd0, 1, 1'b1, 1'b0);
        check("ill_size_en", 32'(last_nrd + last_nwr), 32'd0);
        check("ill_size_rdata", rdata, 32'hFFFFFFBE);
        op(1'b0, 2'b10, 1'b0, 32'd65533, 32'd0, 1, 1'b1, 1'b0);
        check("ill_addr_en", 32'(last_nrd + last_nwr), 32'd0);
        check("ill_addr_rdata", rdata, 32'hFFFFFFBE);
        op(1'b1, 2'b10, 1'b0, 32'd65532, 32'h01020304, 2, 1'b0, 1'b0);
        check("last_legal", {mem[65535], mem[65534], mem[65533], mem[65532]}, 32'h01020304);
        op(1'b1, 2'b00, 1'b0, 32'd400, 32'h00000011, 3, 1'b0, 1'b1);
        check("hold_busy", 32'(last_nbusy), 32'd3);
        check("hold_idle_gap", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("hold_reaccept", 32'(busy), 32'd1);
        req = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin @(posedge clk); #1; end
        check("hold_second_done", 32'(done), 32'd1);
        @(posedge clk); #1;
        check("hold_byte", 32'(mem[400]), 32'h11);
        req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'd300; wdata = 32'h000000AB;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        check("abort_in_wr", 32'(mem_mwr), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_mwr", 32'(mem_mwr), 32'd0);
        check("abort_outs", {busy, done, err, mem_mrd}, 32'd0);
        check("abort_regs", rdata | mem_adr | mem_d_in, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done), 32'd0);
        check("abort_mem300", 32'(mem[300]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        op(1'b0, 2'b00, 1'b0, 32'd1003, 32'd0, 2, 1'b0, 1'b0);
        check("post_reset_lb", rdata, 32'h00000056);
        begin
            int nbad = 0;
            for (int i = 0; i < 2048; i++) nbad += int'(mem[i] != ref_mem[i]);
            for (int i = 65528; i < 65536; i++) nbad += int'(mem[i] != ref_mem[i]);
            check("mem_image", 32'(nbad), 32'd0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
